ib_page_addr_gen: RTL and testbench



---
 rtl/ib_lut_pkg.sv | 23 ++
 rtl/ib_page_cnt.sv | 33 +++
 rtl/ib_page_addr_gen.sv | 123 ++++++++++++
 tb/tb_ib_page_addr_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ib_lut_pkg.sv
// Shared types, default sizing and the one-hot helper for the IB-LUT write path.
package ib_lut_pkg;

    localparam int unsigned RAM_NUM_DEF = 4;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned RAM_NUM_MAX = 64;
    localparam int unsigned SEL_W_MAX   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Callers truncate the result to their own RAM_NUM.
    function automatic logic [RAM_NUM_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
        logic [RAM_NUM_MAX-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ib_page_cnt.sv
// Page counter: load to zero with a latched last index, advance on inc, flag the last page.
module ib_page_cnt
    import ib_lut_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              ram_clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] last_val,
    output logic [ADDR_W-1:0] cnt,
    output logic              is_last_c
);

    logic [ADDR_W-1:0] last_q;

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            cnt    <= '0;
            last_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            last_q <= last_val;
        end else if (inc) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Equality only, so a full-range sweep stops before cnt could wrap.
    assign is_last_c = (cnt == last_q);

endmodule

// File: rtl/ib_page_addr_gen.sv
// Sweeps page addresses 0..last on one selected RAM lane with a one-hot write enable.
module ib_page_addr_gen
    import ib_lut_pkg::*;
#(
    parameter int unsigned RAM_NUM = RAM_NUM_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned SEL_W   = $clog2(RAM_NUM)
) (
    input  logic                      ram_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [SEL_W-1:0]          ram_sel,
    input  logic [ADDR_W-1:0]         page_last,
    input  logic                      stall,
    output logic [RAM_NUM*ADDR_W-1:0] page_addr,
    output logic [RAM_NUM-1:0]        ram_we,
    output logic                      busy,
    output logic                      done,
    output logic                      sel_err
);

    state_e                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [RAM_NUM*ADDR_W-1:0] addr_d;
    logic [RAM_NUM-1:0]        we_d;
    logic                      busy_d, done_d, err_d;
    logic                      cnt_load, cnt_inc;
    logic [ADDR_W-1:0]         cnt;
    logic                      is_last_c;
    logic                      start_ok_c;

    assign start_ok_c = (32'(ram_sel) < RAM_NUM);

    ib_page_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .ram_clk   (ram_clk),
        .rst       (rst),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .last_val  (page_last),
        .cnt       (cnt),
        .is_last_c (is_last_c)
    );

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            page_addr <= '0;
            ram_we    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            page_addr <= addr_d;
            ram_we    <= we_d;
            busy      <= busy_d;
            done      <= done_d;
            sel_err   <= err_d;
        end
    end

    // Next state and next registered outputs; resuming after a stall takes the advance path.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = page_addr;
        we_d     = '0;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                addr_d = '0;
                if (en) begin
                    if (start_ok_c) begin
                        sel_d    = ram_sel;
                        cnt_load = 1'b1;
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        we_d     = RAM_NUM'(onehot(SEL_W_MAX'(ram_sel)));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (stall) begin
                    we_d = '0;
                end else if (is_last_c) begin
                    state_d = ST_DONE;
                    addr_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    addr_d  = '0;
                    for (int unsigned r = 0; r < RAM_NUM; r++) begin
                        if (SEL_W'(r) == sel_q) begin
                            addr_d[r*ADDR_W +: ADDR_W] = cnt + ADDR_W'(1);
                        end
                    end
                    we_d = RAM_NUM'(onehot(SEL_W_MAX'(sel_q)));
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ib_page_addr_gen.sv
// Directed bench for ib_page_addr_gen: default, 3-RAM and 8-RAM/6-bit builds.
module tb_ib_page_addr_gen;

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  we;
    } exp_t;

    logic        ram_clk = 1'b0;
    logic        rst;

    logic        en, stall;
    logic [1:0]  ram_sel;
    logic [4:0]  page_last;
    logic [19:0] page_addr;
    logic [3:0]  ram_we;
    logic        busy, done, sel_err;

    logic        en3, stall3;
    logic [1:0]  sel3;
    logic [4:0]  last3;
    logic [14:0] addr3;
    logic [2:0]  we3;
    logic        busy3, done3, err3;

    logic        en8, stall8;
    logic [2:0]  sel8;
    logic [5:0]  last8;
    logic [47:0] addr8;
    logic [7:0]  we8;
    logic        busy8, done8, err8;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 ram_clk = ~ram_clk;

    ib_page_addr_gen #(.RAM_NUM(4), .ADDR_W(5)) dut (
        .ram_clk(ram_clk), .rst(rst), .en(en), .ram_sel(ram_sel), .page_last(page_last),
        .stall(stall), .page_addr(page_addr), .ram_we(ram_we), .busy(busy), .done(done),
        .sel_err(sel_err)
    );

    ib_page_addr_gen #(.RAM_NUM(3), .ADDR_W(5)) dut3 (
        .ram_clk(ram_clk), .rst(rst), .en(en3), .ram_sel(sel3), .page_last(last3),
        .stall(stall3), .page_addr(addr3), .ram_we(we3), .busy(busy3), .done(done3),
        .sel_err(err3)
    );

    ib_page_addr_gen #(.RAM_NUM(8), .ADDR_W(6)) dut8 (
        .ram_clk(ram_clk), .rst(rst), .en(en8), .ram_sel(sel8), .page_last(last8),
        .stall(stall8), .page_addr(addr8), .ram_we(we8), .busy(busy8), .done(done8),
        .sel_err(err8)
    );

    task automatic tick();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Optionally queue the expected writes, then issue a start and check the first write cycle.
    task automatic start4(input int sel, input int last, input bit push, input bit keep_en);
        exp_t e;
        if (push) begin
            for (int k = 0; k <= last; k++) begin
                e.addr              = '0;
                e.addr[sel*5 +: 5]  = 5'(k);
                e.we                = 4'(1 << sel);
                exp_q.push_back(e);
            end
        end
        en        = 1'b1;
        ram_sel   = 2'(sel);
        page_last = 5'(last);
        tick();
        if (!keep_en) en = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_first_we", 64'(ram_we), 64'(1 << sel));
        check("start_first_page", 64'(page_addr), 64'd0);
    endtask

    // Pop one expected write per we-high cycle until done; optional stall and en noise.
    task automatic run4(input int sel, input int nwrites, input int stall_page,
                        input int stall_len, input bit toggle_en);
        int          cyc, we_cnt, last_we;
        bit          fin;
        logic [4:0]  lane;
        logic [19:0] held;
        exp_t        e;
        cyc = 0; we_cnt = 0; last_we = 0; fin = 1'b0;
        while (!fin && cyc < 300) begin
            if (toggle_en) begin
                en        = cyc[0];
                ram_sel   = 2'd1;
                page_last = 5'd3;
            end
            if (ram_we != '0) begin
                we_cnt++;
                last_we = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_write", 64'(ram_we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sweep_addr", 64'(page_addr), 64'(e.addr));
                    check("sweep_we", 64'(ram_we), 64'(e.we));
                end
                lane = page_addr[sel*5 +: 5];
                if (stall_len > 0 && int'(lane) == stall_page) begin
                    held  = page_addr;
                    stall = 1'b1;
                    for (int s = 0; s < stall_len; s++) begin
                        tick();
                        cyc++;
                        check("stall_we_low", 64'(ram_we), 64'd0);
                        check("stall_addr_hold", 64'(page_addr), 64'(held));
                    end
                    stall = 1'b0;
                end
            end
            if (done) begin
                fin = 1'b1;
                check("done_after_last", 64'(cyc - last_we), 64'd1);
                check("queue_drained", 64'(exp_q.size()), 64'd0);
                check("we_count", 64'(we_cnt), 64'(nwrites));
                check("busy_in_done", 64'(busy), 64'd1);
            end else begin
                tick();
                cyc++;
            end
        end
        if (toggle_en) en = 1'b0;
        if (!fin) check("sweep_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_idle(input string tag);
        tick();
        check(tag, 64'({busy, done, sel_err, ram_we}), 64'd0);
    endtask

    initial begin
        int  k, cyc, seen;
        rst = 1'b1;
        en = 1'b0; stall = 1'b0; ram_sel = '0; page_last = '0;
        en3 = 1'b0; stall3 = 1'b0; sel3 = '0; last3 = '0;
        en8 = 1'b0; stall8 = 1'b0; sel8 = '0; last8 = '0;
        repeat (2) tick();
        check("rst_addr", 64'(page_addr), 64'd0);
        check("rst_ctrl", 64'({busy, done, sel_err, ram_we}), 64'd0);
        check("rst_dut8", 64'({addr8, we8, busy8, done8, err8}), 64'd0);
        rst = 1'b0;
        tick();

        // Basic 15-page sweep on lane 2.
        start4(2, 14, 1'b1, 1'b0);
        run4(2, 15, -1, 0, 1'b0);
        expect_idle("basic_busy_drop");

        // Three-edge stall on page 5 of lane 0.
        start4(0, 9, 1'b1, 1'b0);
        run4(0, 10, 5, 3, 1'b0);
        expect_idle("stall_busy_drop");

        // Single-page sweep on lane 3.
        start4(3, 0, 1'b1, 1'b0);
        run4(3, 1, -1, 0, 1'b0);
        expect_idle("single_busy_drop");

        // Full 5-bit range on lane 1.
        start4(1, 31, 1'b1, 1'b0);
        run4(1, 32, -1, 0, 1'b0);
        expect_idle("full_busy_drop");

        // en/ram_sel/page_last noise while busy must not disturb a lane-0 sweep.
        start4(0, 7, 1'b1, 1'b0);
        run4(0, 8, -1, 0, 1'b1);
        expect_idle("busy_ignore_drop");
        expect_idle("busy_ignore_no_restart");

        // Reset at page 7 abandons the sweep.
        start4(1, 14, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (page_addr[9:5] == 5'd7) break;
            tick();
        end
        check("reach_page7", 64'(page_addr[9:5]), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_addr", 64'(page_addr), 64'd0);
        check("midrst_ctrl", 64'({busy, done, sel_err, ram_we}), 64'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (done || ram_we != '0) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        start4(1, 3, 1'b1, 1'b0);
        run4(1, 4, -1, 0, 1'b0);
        expect_idle("restart_busy_drop");

        // Back-to-back with en held: restart lands last+3 cycles after the first start.
        start4(2, 2, 1'b1, 1'b1);
        run4(2, 3, -1, 0, 1'b0);
        tick();
        check("b2b_gap", 64'({busy, ram_we}), 64'd0);
        tick();
        en = 1'b0;
        check("b2b_restart_we", 64'(ram_we), 64'h4);
        check("b2b_restart_page", 64'(page_addr), 64'd0);
        for (int p = 0; p <= 2; p++) exp_q.push_back('{addr: 20'(p) << 10, we: 4'h4});
        run4(2, 3, -1, 0, 1'b0);
        expect_idle("b2b_busy_drop");

        // RAM_NUM=3: ram_sel=3 is rejected, ram_sel=2 is accepted.
        en3 = 1'b1; sel3 = 2'd3; last3 = 5'd4;
        tick();
        en3 = 1'b0;
        check("sel_err_pulse", 64'(err3), 64'd1);
        check("sel_err_no_we", 64'({busy3, we3}), 64'd0);
        tick();
        check("sel_err_one_cycle", 64'({err3, busy3, we3, addr3}), 64'd0);
        en3 = 1'b1; sel3 = 2'd2; last3 = 5'd0;
        tick();
        en3 = 1'b0;
        check("r3_valid_we", 64'({err3, we3}), 64'h4);
        tick();
        check("r3_done", 64'({done3, busy3}), 64'h3);
        tick();
        check("r3_idle", 64'({done3, busy3}), 64'd0);

        // RAM_NUM=8, ADDR_W=6: full 64-page sweep on lane 7.
        en8 = 1'b1; sel8 = 3'd7; last8 = 6'd63;
        tick();
        en8 = 1'b0;
        k = 0; cyc = 0;
        while (!done8 && cyc < 200) begin
            if (we8 != '0) begin
                check("r8_we", 64'(we8), 64'h80);
                check("r8_page", 64'(addr8[47:42]), 64'(k));
                check("r8_other_lanes", 64'(addr8[41:0]), 64'd0);
                k++;
            end
            tick();
            cyc++;
        end
        check("r8_done_seen", 64'(done8), 64'd1);
        check("r8_pages", 64'(k), 64'd64);
        tick();
        check("r8_idle", 64'({busy8, err8, we8}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
